// File: rtl/fifo_wptr_full.sv
// Write-side control of the asynchronous FIFO: read-pointer synchroniser, write pointers,
// full / almost-full / level generation and a sticky overflow flag, all in the wclk domain.
module fifo_wptr_full #(
   parameter int unsigned depth     = 8,
   parameter int unsigned ptr_width = 3,
   parameter int unsigned af_thresh = 6
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic                 w_en,
   input  logic                 ovf_clr,
   input  logic [ptr_width:0]   g_rptr_async,
   output logic [ptr_width:0]   b_wptr,
   output logic [ptr_width:0]   g_wptr,
   output logic                 full,
   output logic                 almost_full,
   output logic [ptr_width:0]   wr_level,
   output logic                 overflow
);

   localparam logic [ptr_width:0] af_thresh_w = af_thresh[ptr_width:0];

   logic [ptr_width:0] sync1_q;
   logic [ptr_width:0] sync2_q;
   logic [ptr_width:0] b_rptr_sync;
   logic [ptr_width:0] b_next;
   logic [ptr_width:0] g_next;
   logic [ptr_width:0] lvl_next;
   logic [ptr_width:0] g_full_match;
   logic               wr_go;
   logic               full_d;
   logic               almost_full_d;
   logic               overflow_d;

   // Gray-to-binary: bit i is the XOR of all Gray bits from the MSB down to i.
   always_comb begin
      b_rptr_sync = '0;
      for (int i = 0; i <= int'(ptr_width); i++) begin
         b_rptr_sync[i] = ^(sync2_q >> i);
      end
   end

   always_comb begin
      wr_go         = w_en & ~full;
      b_next        = b_wptr + {{ptr_width{1'b0}}, wr_go};
      g_next        = b_next ^ (b_next >> 1);
      // Write pointer one full lap ahead of the read pointer, expressed in Gray code.
      g_full_match  = {~sync2_q[ptr_width:ptr_width-1], sync2_q[ptr_width-2:0]};
      full_d        = (g_next == g_full_match);
      lvl_next      = b_next - b_rptr_sync;
      almost_full_d = (lvl_next >= af_thresh_w);
      overflow_d    = overflow;
      if (w_en && full) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         b_wptr      <= '0;
         g_wptr      <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_level    <= '0;
         overflow    <= 1'b0;
      end else begin
         sync1_q     <= g_rptr_async;
         sync2_q     <= sync1_q;
         b_wptr      <= b_next;
         g_wptr      <= g_next;
         full        <= full_d;
         almost_full <= almost_full_d;
         wr_level    <= lvl_next;
         overflow    <= overflow_d;
      end
   end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side control stage of the asynchronous FIFO; sits directly upstream of the FIFO memory in the wclk domain.
- Synchronises the read-domain Gray pointer into wclk and generates the write pointers that address the memory.
- Produces the full flag that gates memory writes, plus almost-full, fill level and a sticky overflow error.

Parameters:
- depth, 8, number of FIFO entries; must equal 2**ptr_width.
- ptr_width, 3, memory address width; all pointers are ptr_width+1 bits (extra wrap bit).
- af_thresh, 6, fill level at or above which almost_full asserts; legal range 1..depth.

Ports:
- wclk  input  1  write-domain clock; all flops are on its rising edge.
- wrst_n  input  1  asynchronous active-low reset.
- w_en  input  1  write request from the producer.
- ovf_clr  input  1  synchronous clear of the overflow flag.
- g_rptr_async  input  ptr_width+1  Gray read pointer from the rclk domain; not synchronised.
- b_wptr  output  ptr_width+1  binary write pointer to the memory; memory uses the low ptr_width bits.
- g_wptr  output  ptr_width+1  Gray write pointer, for the read-side synchroniser.
- full  output  1  FIFO full; also drives the memory's full input.
- almost_full  output  1  level >= af_thresh.
- wr_level  output  ptr_width+1  write-side view of occupancy, 0..depth.
- overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset: wrst_n low forces every flop to 0 immediately, without waiting for a clock edge.
  - Affected: both synchroniser stages, b_wptr, g_wptr, full, almost_full, wr_level, overflow.
  - Reset mid-operation discards all pointer state; the read side is reset together with this block by system convention.
- Synchroniser: two-flop chain, g_rptr_async -> s1 -> s2 (= g_rptr_sync). No logic between the stages.
- Read-pointer conversion: b_rptr_sync = Gray-to-binary of g_rptr_sync.
  - Bit ptr_width passes through unchanged.
  - Each lower bit i is the XOR of bits ptr_width..i.
- Write accept: wr_go = w_en & ~full.
  - A write request while full is dropped: pointers hold.
  - Memory is gated by the same w_en and full, so accept and memory write are identical.
- Next-state pointers:
  - b_next = b_wptr + wr_go, modulo 2**(ptr_width+1); wraps from all-ones to 0.
  - g_next = b_next ^ (b_next >> 1).
- Registered on each wclk edge: b_wptr <= b_next; g_wptr <= g_next.
- Full: full <= (g_next == {~g_rptr_sync[ptr_width:ptr_width-1], g_rptr_sync[ptr_width-2:0]}).
  - full asserts on the same edge that accepts the depth-th outstanding write.
  - No combinational path from w_en to full.
- Level: lvl_next = b_next - b_rptr_sync, modulo 2**(ptr_width+1).
  - wr_level <= lvl_next.
  - almost_full <= (lvl_next >= af_thresh).
- Pessimism: a read-side pointer advance reaches full, wr_level and almost_full 3 wclk edges after g_rptr_async changes (2 sync + 1 register).
  - Full may therefore stay high longer than necessary; it must never be low while the FIFO is actually full.
- Overflow:
  - Set on an edge where w_en & full.
  - Cleared on an edge where ovf_clr and not set.
  - Set wins if set and clear occur in the same cycle.
  - Otherwise holds.
- Simultaneous read advance and write on one edge: level and full are computed from b_next and the current g_rptr_sync, so the net level is unchanged.
- Pointer bus safety: g_wptr changes at most one bit per wclk edge, and only from a flop output.

Test Plan:
- Reset, then hold w_en=0 for 4 edges -> b_wptr=0, g_wptr=0, full=0, wr_level=0, overflow=0.
  - Then pulse wrst_n low between edges -> all outputs 0 before the next edge.
- g_rptr_async=0; w_en=1 for 8 edges -> b_wptr counts 1..8, final g_wptr=4'b1100.
  - almost_full rises on the 6th accepted write; wr_level=6 at that point.
  - full rises on the 8th; wr_level=8.
- From full, w_en=1 for 2 more edges -> b_wptr holds at 8 and overflow=1.
  - Then ovf_clr=1 with w_en=0 -> overflow=0.
  - ovf_clr=1 and w_en=1 in the same cycle while full -> overflow stays 1.
- From full at b_wptr=8, set g_rptr_async=4'b0010 (binary 3) -> full falls and wr_level=5 exactly 3 edges later, not earlier.
  - almost_full falls on the same edge.
- Wrap-around: step g_rptr_async through Gray codes keeping the level at 2, writing continuously for 20 writes.
  - b_wptr wraps 15 -> 0 (g_wptr 4'b1000 -> 4'b0000).
  - full never asserts.
  - g_wptr Hamming distance <= 1 on every edge.
- Simultaneous events: level 7, with a read advance of 1 arriving at s2 on the same edge as a write -> wr_level stays 7 and full=0.
